// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a first-word-fall-through receive FIFO and framing/overrun pulses
module uart_rx #(
  parameter int CLKS_PER_BIT = 208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rx_s, expired, push, do_push, pop, full;
  logic [7:0] mem_q [FIFO_DEPTH];
  always_comb begin
    sync_d = {sync_q[0], rx};
    rx_s = sync_q[1];
    expired = cnt_q == 16'd0;
    state_d = state_q;
    cnt_d = expired ? cnt_q : cnt_q - 16'd1;
    idx_d = idx_q;
    shift_d = shift_q;
    push = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d = HALF;
      end
      START: if (expired) begin
        state_d = rx_s ? IDLE : DATA;
        cnt_d = FULL;
        idx_d = 3'd0;
      end
      DATA: if (expired) begin
        shift_d = {rx_s, shift_q[7:1]};
        cnt_d = FULL;
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (expired) begin
        push = rx_s;
        frame_err_d = !rx_s;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: state_d = rx_s ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
    full = count_q == CW'(FIFO_DEPTH);
    rd_valid = count_q != '0;
    pop = rd_valid & rd_ready;
    do_push = push & (!full | pop);
    overrun_d = push & full & !pop;
    count_d = count_q + CW'(do_push) - CW'(pop);
    wp_d = do_push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    rd_data = rd_valid ? mem_q[rp_q] : 8'd0;
    busy = state_q != IDLE;
    frame_err = frame_err_q;
    overrun = overrun_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      count_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      count_q <= count_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= shift_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx against a frame-level reference model
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 32;
  localparam int DEPTH = 4;
  localparam real BIT_NS = CPB * 10.0;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic rd_valid, frame_err, overrun, busy;
  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, stop_cyc = -1000, rise_cyc = 0;
  int model_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, exp_ferr = 0, exp_ovr = 0;
  logic [7:0] exp_q[$];
  logic valid_prev = 1'b0;
  bit rnd_done;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rd_ready = v;
  endtask
  // Model: a frame with a good stop bit is accepted unless the FIFO already holds DEPTH bytes
  // and no pop coincides with the push; a bad stop bit yields one framing error and no byte.
  task automatic send(input logic [7:0] b, input real f, input logic stop_bit, input logic pop_at_push);
    real bt;
    bt = BIT_NS * f;
    @(negedge clk);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bt);
    end
    stop_cyc = cyc;
    if (!stop_bit) exp_ferr++;
    else if (model_cnt < DEPTH || pop_at_push) begin
      exp_q.push_back(b);
      model_cnt++;
    end else exp_ovr++;
    rx = stop_bit;
    #(bt);
    if (stop_bit) rx = 1'b1;
  endtask
  always @(negedge clk) begin
    if (rst) valid_prev = 1'b0;
    else begin
      if (frame_err || overrun) chk("flags_exclusive", int'(frame_err & overrun), 0);
      ferr_cnt += int'(frame_err);
      ovr_cnt += int'(overrun);
      if (rd_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = rd_valid;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %02h expected none", rd_data);
        end else begin
          chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
          model_cnt--;
        end
      end
    end
  end
  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    #(3 * BIT_NS);
    chk("busy_mid_frame", int'(busy), 1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    rst = 1'b0;
    set_ready(1'b1);
    #(20 * BIT_NS);
    chk("idle_rd_valid", int'(rd_valid), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_frame_err", ferr_cnt, 0);
    send(8'h55, 1.0, 1'b1, 1'b0);
    send(8'hA3, 1.0, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk_rng("rise_latency", rise_cyc - stop_cyc, CPB / 2 + 1, CPB / 2 + 3);
    chk("basic_drained", exp_q.size(), 0);
    set_ready(1'b0);
    for (int i = 1; i <= 5; i++) send(8'(i), 1.0, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("overrun_pulses", ovr_cnt, exp_ovr);
    chk("overrun_exp", exp_ovr, 1);
    chk("full_rd_valid", int'(rd_valid), 1);
    set_ready(1'b1);
    repeat (20) @(negedge clk);
    chk("overrun_drained", exp_q.size(), 0);
    chk("overrun_empty", int'(rd_valid), 0);
    set_ready(1'b0);
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1.0, 1'b1, 1'b0);
    stop_cyc = -1000;
    hit = 1'b0;
    fork
      send(8'h15, 1.0, 1'b1, 1'b1);
      for (int k = 0; k < 12 * CPB; k++) begin
        @(posedge clk);
        #1;
        if (cyc == stop_cyc + CPB / 2 + 2) begin
          rd_ready = 1'b1;
          hit = 1'b1;
          @(posedge clk);
          #1 rd_ready = 1'b0;
          break;
        end
      end
    join
    chk("simpop_window_found", int'(hit), 1);
    repeat (CPB) @(negedge clk);
    chk("simpop_no_overrun", ovr_cnt, exp_ovr);
    chk("simpop_count", exp_q.size(), 4);
    set_ready(1'b1);
    repeat (20) @(negedge clk);
    chk("simpop_drained", exp_q.size(), 0);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_rd_valid", int'(rd_valid), 0);
    chk("glitch_frame_err", ferr_cnt, exp_ferr);
    chk("glitch_overrun", ovr_cnt, exp_ovr);
    send(8'hFF, 1.0, 1'b0, 1'b0);
    #(3 * BIT_NS);
    chk("break_busy", int'(busy), 1);
    chk("break_frame_err", ferr_cnt, 1);
    rx = 1'b1;
    #(2 * BIT_NS);
    send(8'h3C, 1.0, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("break_frame_err_once", ferr_cnt, exp_ferr);
    chk("break_drained", exp_q.size(), 0);
    send(8'h96, 1.03, 1'b1, 1'b0);
    #(BIT_NS);
    send(8'h96, 0.97, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("baud_drained", exp_q.size(), 0);
    chk("baud_frame_err", ferr_cnt, exp_ferr);
    chk("baud_overrun", ovr_cnt, exp_ovr);
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(8'($urandom), 0.98 + 0.04 * real'($urandom_range(0, 100)) / 100.0, 1'b1, 1'b0);
          #(real'($urandom_range(0, 3)) * BIT_NS);
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk);
        #1 rd_ready = 1'($urandom_range(0, 1));
      end
    join
    set_ready(1'b1);
    repeat (40) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_frame_err", ferr_cnt, exp_ferr);
    chk("final_overrun", ovr_cnt, exp_ovr);
    chk("final_rd_valid", int'(rd_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
